// File: rtl/temp_monitor.sv
// temp_monitor: brings the DHT11 capture stage (temp / done / Inicio) into
// the system clock domain, range-checks each captured sample, keeps a
// 4-sample moving average, and drives a hysteresis over-temperature alarm
// plus a stale-data flag.
//
// Pipeline, for an Inicio rise first sampled at clk edge k:
//   edge k+1 : Inicio_s2 high, Inicio_s3 still low -> capture_evt
//   edge k+2 : cap_q set, temp registered into smp_q
//   edge k+3 : accept/reject applied to buffer, sum, fill, reject_cnt;
//              new_sample high, stale counter cleared
//   edge k+4 : avg_temp / avg_valid / alarm reflect the new sample
module temp_monitor #(
    parameter int unsigned TH_HIGH      = 30,
    parameter int unsigned TH_LOW       = 28,
    parameter int unsigned TMAX         = 60,
    parameter int unsigned STALE_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Inicio,
    input  logic       done,
    input  logic [7:0] temp,
    output logic       new_sample,
    output logic [7:0] avg_temp,
    output logic       avg_valid,
    output logic       alarm,
    output logic       stale,
    output logic [7:0] reject_cnt
);

    localparam logic [7:0]  TH_HIGH_B  = 8'(TH_HIGH);
    localparam logic [7:0]  TH_LOW_B   = 8'(TH_LOW);
    localparam logic [7:0]  TMAX_B     = 8'(TMAX);
    localparam logic [29:0] STALE_MAX  = 30'(STALE_CYCLES);
    localparam logic [2:0]  FILL_FULL  = 3'd4;

    // Synchroniser and edge-detect flops
    logic inicio_s1_q, inicio_s1_d;
    logic inicio_s2_q, inicio_s2_d;
    logic inicio_s3_q, inicio_s3_d;
    logic done_s1_q,   done_s1_d;
    logic done_s2_q,   done_s2_d;

    // Capture stage
    logic       cap_q, cap_d;
    logic [7:0] smp_q, smp_d;

    // Accept/reject stage
    logic       new_sample_q, new_sample_d;
    logic       acc_q, acc_d;
    logic [7:0] smp_buf_q [4];
    logic [7:0] smp_buf_d [4];
    logic [9:0] sum_q, sum_d;
    logic [2:0] fill_q, fill_d;
    logic [7:0] reject_cnt_q, reject_cnt_d;

    // Output stage
    logic [7:0] avg_temp_q, avg_temp_d;
    logic       avg_valid_q, avg_valid_d;
    logic       alarm_q, alarm_d;

    // Stale watchdog
    logic [29:0] stale_cnt_q, stale_cnt_d;

    // Combinational helpers
    logic capture_evt;
    logic is_reject;
    logic is_accept;

    // Next-state logic for the whole datapath
    always_comb begin
        // Synchronisers simply shift the asynchronous inputs along.
        inicio_s1_d = Inicio;
        inicio_s2_d = inicio_s1_q;
        inicio_s3_d = inicio_s2_q;
        done_s1_d   = done;
        done_s2_d   = done_s1_q;

        // A rise of Inicio only counts once the DHT11 stage has loaded data.
        capture_evt = inicio_s2_q & ~inicio_s3_q & done_s2_q;

        // temp is held stable for a long time after Inicio rises, so it is
        // safe to sample it directly once the synchronised edge is seen.
        cap_d = capture_evt;
        smp_d = capture_evt ? temp : smp_q;

        is_reject = cap_q & (smp_q > TMAX_B);
        is_accept = cap_q & ~(smp_q > TMAX_B);

        new_sample_d = cap_q;
        acc_d        = is_accept;

        // Shift buffer and running sum; an empty slot holds 0, so the same
        // subtract-oldest update works while the buffer is still filling.
        for (int i = 0; i < 4; i++) begin
            smp_buf_d[i] = smp_buf_q[i];
        end
        sum_d  = sum_q;
        fill_d = fill_q;
        if (is_accept) begin
            smp_buf_d[0] = smp_q;
            for (int i = 1; i < 4; i++) begin
                smp_buf_d[i] = smp_buf_q[i-1];
            end
            sum_d = sum_q - {2'b00, smp_buf_q[3]} + {2'b00, smp_q};
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 3'd1;
            end
        end

        // Rejected-sample counter saturates instead of wrapping.
        reject_cnt_d = reject_cnt_q;
        if (is_reject && (reject_cnt_q != 8'hFF)) begin
            reject_cnt_d = reject_cnt_q + 8'd1;
        end

        // Average is only meaningful once four samples are in the buffer.
        if (fill_q == FILL_FULL) begin
            avg_temp_d  = sum_q[9:2];
            avg_valid_d = 1'b1;
        end else begin
            avg_temp_d  = 8'd0;
            avg_valid_d = 1'b0;
        end

        // Hysteresis alarm: re-evaluated only right after an accept, using
        // the average that includes that sample; held otherwise.
        alarm_d = alarm_q;
        if (fill_q != FILL_FULL) begin
            alarm_d = 1'b0;
        end else if (acc_q) begin
            if (avg_temp_d >= TH_HIGH_B) begin
                alarm_d = 1'b1;
            end else if (avg_temp_d <= TH_LOW_B) begin
                alarm_d = 1'b0;
            end
        end

        // Any capture (accepted or rejected) restarts the watchdog; it is
        // cleared on the same edge that raises new_sample, so a capture wins
        // over reaching the threshold.
        stale_cnt_d = stale_cnt_q;
        if (cap_q) begin
            stale_cnt_d = 30'd0;
        end else if (stale_cnt_q != STALE_MAX) begin
            stale_cnt_d = stale_cnt_q + 30'd1;
        end
    end

    // State registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inicio_s1_q  <= 1'b0;
            inicio_s2_q  <= 1'b0;
            inicio_s3_q  <= 1'b0;
            done_s1_q    <= 1'b0;
            done_s2_q    <= 1'b0;
            cap_q        <= 1'b0;
            smp_q        <= 8'd0;
            new_sample_q <= 1'b0;
            acc_q        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                smp_buf_q[i] <= 8'd0;
            end
            sum_q        <= 10'd0;
            fill_q       <= 3'd0;
            reject_cnt_q <= 8'd0;
            avg_temp_q   <= 8'd0;
            avg_valid_q  <= 1'b0;
            alarm_q      <= 1'b0;
            stale_cnt_q  <= 30'd0;
        end else begin
            inicio_s1_q  <= inicio_s1_d;
            inicio_s2_q  <= inicio_s2_d;
            inicio_s3_q  <= inicio_s3_d;
            done_s1_q    <= done_s1_d;
            done_s2_q    <= done_s2_d;
            cap_q        <= cap_d;
            smp_q        <= smp_d;
            new_sample_q <= new_sample_d;
            acc_q        <= acc_d;
            for (int i = 0; i < 4; i++) begin
                smp_buf_q[i] <= smp_buf_d[i];
            end
            sum_q        <= sum_d;
            fill_q       <= fill_d;
            reject_cnt_q <= reject_cnt_d;
            avg_temp_q   <= avg_temp_d;
            avg_valid_q  <= avg_valid_d;
            alarm_q      <= alarm_d;
            stale_cnt_q  <= stale_cnt_d;
        end
    end

    assign new_sample = new_sample_q;
    assign avg_temp   = avg_temp_q;
    assign avg_valid  = avg_valid_q;
    assign alarm      = alarm_q;
    assign reject_cnt = reject_cnt_q;
    assign stale      = (stale_cnt_q == STALE_MAX);

endmodule

// File: tb/tb_temp_monitor.sv
// Directed bench for temp_monitor: vector table for the averaging/alarm
// path plus hand-written sequences for latency, reject saturation, stale
// timing and mid-stream reset.
module tb_temp_monitor;

    logic       clk;
    logic       rst_n;
    logic       Inicio;
    logic       done;
    logic [7:0] temp;
    logic       new_sample;
    logic [7:0] avg_temp;
    logic       avg_valid;
    logic       alarm;
    logic       stale;
    logic [7:0] reject_cnt;

    int checks   = 0;
    int failures = 0;

    temp_monitor #(
        .TH_HIGH(30),
        .TH_LOW(28),
        .TMAX(60),
        .STALE_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Inicio(Inicio),
        .done(done),
        .temp(temp),
        .new_sample(new_sample),
        .avg_temp(avg_temp),
        .avg_valid(avg_valid),
        .alarm(alarm),
        .stale(stale),
        .reject_cnt(reject_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] t;
        logic [7:0] exp_avg;
        logic       exp_valid;
        logic       exp_alarm;
        logic [7:0] exp_rej;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Raise Inicio with temp from a negedge; watch 8 cycles after the first
    // sampling edge k. j counts the negedge following edge k+j.
    task automatic send(input logic [7:0] t, input bit exp_pulse, input string tag,
                        output logic [7:0] avg3, output logic valid3,
                        output logic [7:0] avg4);
        int npulse;
        int pulse_j;
        npulse  = 0;
        pulse_j = -1;
        avg3    = 8'd0;
        valid3  = 1'b0;
        avg4    = 8'd0;
        temp    = t;
        Inicio  = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (new_sample === 1'b1) begin
                npulse++;
                pulse_j = j;
            end
            if (j == 3) begin
                avg3   = avg_temp;
                valid3 = avg_valid;
            end
            if (j == 4) avg4 = avg_temp;
            if (j == 5) Inicio = 1'b0;
        end
        if (exp_pulse) begin
            chk({tag, "_pulse_count"}, npulse, 1);
            chk({tag, "_pulse_at"}, pulse_j, 3);
        end else begin
            chk({tag, "_no_pulse"}, npulse, 0);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] a3;
        logic       v3;
        logic [7:0] a4;

        vecs[0]  = '{8'd20, 8'd0,  1'b0, 1'b0, 8'd0};
        vecs[1]  = '{8'd22, 8'd0,  1'b0, 1'b0, 8'd0};
        vecs[2]  = '{8'd24, 8'd0,  1'b0, 1'b0, 8'd0};
        vecs[3]  = '{8'd26, 8'd23, 1'b1, 1'b0, 8'd0};
        vecs[4]  = '{8'd29, 8'd25, 1'b1, 1'b0, 8'd0};
        vecs[5]  = '{8'd29, 8'd27, 1'b1, 1'b0, 8'd0};
        vecs[6]  = '{8'd29, 8'd28, 1'b1, 1'b0, 8'd0};
        vecs[7]  = '{8'd29, 8'd29, 1'b1, 1'b0, 8'd0};
        vecs[8]  = '{8'd31, 8'd29, 1'b1, 1'b0, 8'd0};
        vecs[9]  = '{8'd31, 8'd30, 1'b1, 1'b1, 8'd0};
        vecs[10] = '{8'd31, 8'd30, 1'b1, 1'b1, 8'd0};
        vecs[11] = '{8'd31, 8'd31, 1'b1, 1'b1, 8'd0};
        vecs[12] = '{8'd29, 8'd30, 1'b1, 1'b1, 8'd0};
        vecs[13] = '{8'd29, 8'd30, 1'b1, 1'b1, 8'd0};
        vecs[14] = '{8'd29, 8'd29, 1'b1, 1'b1, 8'd0};
        vecs[15] = '{8'd29, 8'd29, 1'b1, 1'b1, 8'd0};
        vecs[16] = '{8'd27, 8'd28, 1'b1, 1'b0, 8'd0};
        vecs[17] = '{8'd27, 8'd28, 1'b1, 1'b0, 8'd0};
        vecs[18] = '{8'd27, 8'd27, 1'b1, 1'b0, 8'd0};
        vecs[19] = '{8'd27, 8'd27, 1'b1, 1'b0, 8'd0};
        vecs[20] = '{8'd61, 8'd27, 1'b1, 1'b0, 8'd1};
        vecs[21] = '{8'd60, 8'd35, 1'b1, 1'b1, 8'd1};

        // Reset state
        rst_n  = 1'b0;
        Inicio = 1'b0;
        done   = 1'b0;
        temp   = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_new_sample", new_sample, 0);
        chk("rst_avg_temp", avg_temp, 0);
        chk("rst_avg_valid", avg_valid, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_stale", stale, 0);
        chk("rst_reject_cnt", reject_cnt, 0);
        rst_n = 1'b1;
        done  = 1'b1;
        repeat (4) @(negedge clk);

        // Vector table: fill, average, hysteresis, reject, TMAX boundary
        for (int i = 0; i < 22; i++) begin
            send(vecs[i].t, 1'b1, $sformatf("vec%0d", i), a3, v3, a4);
            chk($sformatf("vec%0d_avg_at_k4", i), a4, vecs[i].exp_avg);
            chk($sformatf("vec%0d_avg", i), avg_temp, vecs[i].exp_avg);
            chk($sformatf("vec%0d_valid", i), avg_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_alarm", i), alarm, vecs[i].exp_alarm);
            chk($sformatf("vec%0d_reject_cnt", i), reject_cnt, vecs[i].exp_rej);
            if (i == 3) begin
                // Average must not move before edge k+4
                chk("lat_avg_at_k3", a3, 0);
                chk("lat_valid_at_k3", v3, 0);
            end
        end

        // Reject saturation: 256 more over-range samples
        for (int i = 0; i < 256; i++) begin
            send(8'd200, 1'b1, "sat", a3, v3, a4);
            if (i == 0) chk("sat_first", reject_cnt, 2);
        end
        chk("sat_reject_cnt", reject_cnt, 255);
        chk("sat_avg_unchanged", avg_temp, 35);
        chk("sat_valid_unchanged", avg_valid, 1);

        // Stale after a long quiet period
        repeat (120) @(negedge clk);
        chk("stale_set", stale, 1);

        // Capture clears stale in the new_sample cycle; threshold boundary
        temp   = 8'd35;
        Inicio = 1'b1;
        for (int j = 0; j < 105; j++) begin
            @(negedge clk);
            if (j == 2) chk("stale_before_clear", stale, 1);
            if (j == 3) begin
                chk("stale_clear_pulse", new_sample, 1);
                chk("stale_clear", stale, 0);
            end
            if (j == 5) Inicio = 1'b0;
            if (j == 102) chk("stale_cnt99", stale, 0);
            if (j == 103) chk("stale_cnt100", stale, 1);
        end
        chk("stale_avg_37", avg_temp, 37);

        // Inicio rise with done low is ignored
        done = 1'b0;
        repeat (4) @(negedge clk);
        send(8'd50, 1'b0, "nodone", a3, v3, a4);
        chk("nodone_stale_held", stale, 1);
        chk("nodone_avg_held", avg_temp, 37);
        done = 1'b1;
        repeat (4) @(negedge clk);

        // Mid-stream reset after 3 accepts
        for (int i = 0; i < 3; i++) send(8'd40, 1'b1, "pre_rst", a3, v3, a4);
        chk("pre_rst_alarm", alarm, 1);
        chk("pre_rst_avg", avg_temp, 38);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_new_sample", new_sample, 0);
        chk("arst_avg_temp", avg_temp, 0);
        chk("arst_avg_valid", avg_valid, 0);
        chk("arst_alarm", alarm, 0);
        chk("arst_stale", stale, 0);
        chk("arst_reject_cnt", reject_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) send(8'd40, 1'b1, "post_rst", a3, v3, a4);
        chk("post_rst3_valid", avg_valid, 0);
        chk("post_rst3_avg", avg_temp, 0);
        chk("post_rst3_alarm", alarm, 0);
        send(8'd40, 1'b1, "post_rst4", a3, v3, a4);
        chk("post_rst4_valid", avg_valid, 1);
        chk("post_rst4_avg", avg_temp, 40);
        chk("post_rst4_alarm", alarm, 1);
        chk("post_rst4_reject_cnt", reject_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
